// File: rtl/extbus_arbiter.sv
// +---------------------------------------------------------------------------+
// | extbus_arbiter : round-robin arbiter and byte-serial external bus driver  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module extbus_arbiter #(
  parameter int TURN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        ack0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic [7:0]  bus_out,
  output logic [7:0]  bus_dout,
  output logic [7:0]  bus_oe,
  input  logic [7:0]  bus_din,
  output logic        bus_strobe,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_CTRL  = 3'd2,
    S_TURNW = 3'd3,
    S_DATA  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] TURN_LAST = (TURN == 0) ? 2'd0 : 2'(TURN - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        id_q, id_d;
  logic        we_q, we_d;
  logic        last_q, last_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  bus_out_q, bus_out_d;
  logic [7:0]  bus_dout_q, bus_dout_d;
  logic [7:0]  bus_oe_q, bus_oe_d;
  logic        strobe_q, strobe_d;
  logic        busy_q, busy_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        win;

  // On a tie the requester not served last wins; a lone request always wins.
  assign win = (req0 && req1) ? ~last_q : req1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    we_d    = we_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d = S_ADDR;
          cnt_d   = 2'd0;
          id_d    = win;
          we_d    = win ? we1 : we0;
          addr_d  = win ? addr1 : addr0;
          wdata_d = win ? wdata1 : wdata0;
        end
      end
      S_ADDR: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = S_CTRL;
      end
      S_CTRL: begin
        cnt_d   = 2'd0;
        state_d = (TURN == 0) ? S_DATA : S_TURNW;
      end
      S_TURNW: begin
        if (cnt_q == TURN_LAST) begin
          cnt_d   = 2'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_DATA: begin
        if (!we_q) rdata_d[{cnt_q, 3'b000} +: 8] = bus_din;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        last_d  = id_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so the registered pins line
  // up with the state they describe.
  always_comb begin
    bus_out_d  = 8'h00;
    bus_dout_d = 8'h00;
    bus_oe_d   = 8'h00;
    strobe_d   = 1'b0;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    busy_d     = (state_d != S_IDLE);

    case (state_d)
      S_ADDR: begin
        bus_out_d = addr_d[{cnt_d, 3'b000} +: 8];
        strobe_d  = (cnt_d == 2'd0);
      end
      S_CTRL: bus_out_d = {6'b000000, id_d, we_d};
      S_DATA: begin
        if (we_d) begin
          bus_dout_d = wdata_d[{cnt_d, 3'b000} +: 8];
          bus_oe_d   = 8'hFF;
        end
      end
      S_DONE: begin
        ack0_d = ~id_d;
        ack1_d = id_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      last_q     <= 1'b1;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      bus_out_q  <= 8'h00;
      bus_dout_q <= 8'h00;
      bus_oe_q   <= 8'h00;
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      we_q       <= we_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      bus_out_q  <= bus_out_d;
      bus_dout_q <= bus_dout_d;
      bus_oe_q   <= bus_oe_d;
      strobe_q   <= strobe_d;
      busy_q     <= busy_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign rdata      = rdata_q;
  assign bus_out    = bus_out_q;
  assign bus_dout   = bus_dout_q;
  assign bus_oe     = bus_oe_q;
  assign bus_strobe = strobe_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire
